// File: rtl/instr_sequencer_pkg.sv
// rtl/instr_sequencer_pkg.sv - shared state encoding and default sizing for the instruction sequencer
package instr_sequencer_pkg;

    localparam int DEFAULT_DEPTH   = 16;
    localparam int DEFAULT_TIMEOUT = 255;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_LOW,
        WAIT_HIGH,
        NEXT,
        DONE,
        ERROR
    } seq_state_t;

endpackage

// File: rtl/instr_sequencer_prog_mem.sv
// rtl/instr_sequencer_prog_mem.sv - program memory, synchronous write and combinational read
module instr_sequencer_prog_mem #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [15:0]              wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [15:0]              rdata
);

    // Contents survive reset on purpose so a loaded program can be rerun.
    logic [15:0] mem [DEPTH];

    // Write port: one word per strobed edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - issues stored instructions to the cpu one at a time with handshake and timeout
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [15:0]              prog_data,
    input  logic                     start,
    input  logic [$clog2(DEPTH):0]   count,
    output logic [15:0]              cpu_in,
    output logic                     cpu_load,
    output logic                     cpu_s,
    input  logic                     cpu_w,
    input  logic [15:0]              cpu_out,
    output logic [15:0]              last_out,
    output logic [$clog2(DEPTH)-1:0] pc,
    output logic                     busy,
    output logic                     done,
    output logic                     error
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT);

    seq_state_t    state, state_nxt;
    logic [AW-1:0] pc_nxt;
    logic [CW-1:0] cnt_q, cnt_nxt;
    logic [TW-1:0] tmo_q, tmo_nxt, tmo_inc;
    logic [15:0]   last_nxt;
    logic [15:0]   mem_rdata;
    logic          mem_we;

    // Writes are locked out while a program is running so the issued words stay stable.
    assign mem_we = prog_we & ~busy;

    instr_sequencer_prog_mem #(
        .DEPTH(DEPTH)
    ) prog_mem (
        .clk  (clk),
        .we   (mem_we),
        .waddr(prog_addr),
        .wdata(prog_data),
        .raddr(pc),
        .rdata(mem_rdata)
    );

    // The instruction bus is quiet only while idle; elsewhere it presents the current word.
    assign cpu_in = (state == IDLE) ? 16'h0000 : mem_rdata;

    // State register and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            pc       <= '0;
            cnt_q    <= '0;
            tmo_q    <= '0;
            last_out <= '0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            cnt_q    <= cnt_nxt;
            tmo_q    <= tmo_nxt;
            last_out <= last_nxt;
        end
    end

    // Next-state and output decode; a cpu handshake edge wins over a simultaneous timeout.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        cnt_nxt   = cnt_q;
        tmo_nxt   = tmo_q;
        last_nxt  = last_out;
        cpu_load  = 1'b0;
        cpu_s     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        tmo_inc   = tmo_q + TW'(1);

        case (state)
            IDLE, DONE, ERROR: begin
                done  = (state == DONE);
                error = (state == ERROR);
                if (start) begin
                    pc_nxt    = '0;
                    cnt_nxt   = (count > DEPTH_C) ? DEPTH_C : count;
                    state_nxt = (cnt_nxt == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                busy      = 1'b1;
                cpu_load  = 1'b1;
                state_nxt = START;
            end
            START: begin
                busy      = 1'b1;
                cpu_s     = 1'b1;
                tmo_nxt   = '0;
                state_nxt = WAIT_LOW;
            end
            WAIT_LOW: begin
                busy    = 1'b1;
                tmo_nxt = tmo_inc;
                if (!cpu_w) begin
                    state_nxt = WAIT_HIGH;
                end else if (tmo_inc == TIMEOUT_C) begin
                    state_nxt = ERROR;
                end
            end
            WAIT_HIGH: begin
                busy    = 1'b1;
                tmo_nxt = tmo_inc;
                if (cpu_w) begin
                    last_nxt  = cpu_out;
                    state_nxt = NEXT;
                end else if (tmo_inc == TIMEOUT_C) begin
                    state_nxt = ERROR;
                end
            end
            NEXT: begin
                busy = 1'b1;
                if (({1'b0, pc} + CW'(1)) == cnt_q) begin
                    state_nxt = DONE;
                end else begin
                    pc_nxt    = pc + AW'(1);
                    state_nxt = LOAD;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - scoreboard bench for instr_sequencer with a small behavioural cpu
module tb_instr_sequencer;

    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [15:0] prog_data;
    logic        start;
    logic [4:0]  count;
    logic [15:0] cpu_in;
    logic        cpu_load;
    logic        cpu_s;
    logic        cpu_w = 1'b1;
    logic [15:0] cpu_out = 16'h0000;
    logic [15:0] last_out;
    logic [3:0]  pc;
    logic        busy;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

    instr_sequencer #(
        .DEPTH  (DEPTH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .prog_we  (prog_we),
        .prog_addr(prog_addr),
        .prog_data(prog_data),
        .start    (start),
        .count    (count),
        .cpu_in   (cpu_in),
        .cpu_load (cpu_load),
        .cpu_s    (cpu_s),
        .cpu_w    (cpu_w),
        .cpu_out  (cpu_out),
        .last_out (last_out),
        .pc       (pc),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    // Behavioural cpu: MOV Rn,#imm8 (110 10) and ADD Rd,Rn,Rm{shift} (101).
    logic [15:0] regs [8];
    logic [15:0] cpu_ir;
    int          cpu_delay = 0;
    int          cpu_cnt   = 0;
    bit          cpu_stuck = 1'b0;
    bit          cpu_run   = 1'b0;

    function automatic logic [15:0] cpu_result(input logic [15:0] ir);
        logic [15:0] rm;
        rm = regs[ir[2:0]];
        case (ir[4:3])
            2'b01:   rm = rm << 1;
            2'b10:   rm = rm >> 1;
            2'b11:   rm = {rm[15], rm[15:1]};
            default: rm = rm;
        endcase
        if (ir[15:13] == 3'b110) return {8'h00, ir[7:0]};
        return regs[ir[10:8]] + rm;
    endfunction

    always @(posedge clk) begin
        if (cpu_load) cpu_ir <= cpu_in;
        if (cpu_s && !cpu_stuck) begin
            cpu_w   <= 1'b0;
            cpu_run <= 1'b1;
            cpu_cnt <= cpu_delay;
        end else if (cpu_run) begin
            if (cpu_cnt == 0) begin
                cpu_run <= 1'b0;
                cpu_w   <= 1'b1;
                cpu_out <= cpu_result(cpu_ir);
                regs[(cpu_ir[15:13] == 3'b110) ? cpu_ir[10:8] : cpu_ir[7:5]] <= cpu_result(cpu_ir);
            end else begin
                cpu_cnt <= cpu_cnt - 1;
            end
        end
    end

    // Monitor: records every issued instruction word and control pulse.
    logic [15:0] obs_q [$];
    logic [15:0] exp_q [$];
    int obs_rd   = 0;
    int load_cnt = 0;
    int s_cnt    = 0;
    int both_cnt = 0;

    always @(negedge clk) begin
        if (cpu_load) begin
            obs_q.push_back(cpu_in);
            load_cnt++;
        end
        if (cpu_s) s_cnt++;
        if (cpu_load && cpu_s) both_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic write_word(input logic [3:0] a, input logic [15:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        @(negedge clk);
        prog_we   = 1'b0;
    endtask

    task automatic pulse_start(input logic [4:0] c);
        start = 1'b1;
        count = c;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max, output int cyc, output bit ok);
        cyc = 1;
        while (!done && !error && cyc < max) begin
            @(negedge clk);
            cyc++;
        end
        ok = done;
    endtask

    task automatic test_reset();
        reset = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0; start = 1'b0; count = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, error, cpu_load, cpu_s} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: busy,done,error,load,s=%b expected 00000", {busy, done, error, cpu_load, cpu_s});
        end
        checks++;
        if (cpu_in !== 16'h0 || pc !== 4'h0 || last_out !== 16'h0) begin
            errors++; $display("FAIL reset_data: cpu_in=%h pc=%h last_out=%h expected all 0", cpu_in, pc, last_out);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_run();
        int cyc; bit ok; int l0, s0, b0; logic [15:0] e;
        write_word(4'd0, 16'hD007);
        write_word(4'd1, 16'hD102);
        write_word(4'd2, 16'hA148);
        cpu_delay = 0;
        l0 = load_cnt; s0 = s_cnt; b0 = both_cnt;
        exp_q.push_back(16'hD007); exp_q.push_back(16'hD102); exp_q.push_back(16'hA148);
        pulse_start(5'd3);
        wait_done(200, cyc, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_done: done=%b error=%b expected done=1", done, error); end
        checks++;
        if (cyc != 16) begin errors++; $display("FAIL basic_latency: %0d cycles expected 16", cyc); end
        checks++;
        if (load_cnt - l0 != 3 || s_cnt - s0 != 3) begin
            errors++; $display("FAIL basic_pulses: loads=%0d s=%0d expected 3 and 3", load_cnt - l0, s_cnt - s0);
        end
        checks++;
        if (both_cnt != b0) begin errors++; $display("FAIL basic_overlap: %0d cycles with load and s expected 0", both_cnt - b0); end
        checks++;
        if (regs[2] !== 16'h0010) begin errors++; $display("FAIL basic_r2: R2=%h expected 0010", regs[2]); end
        checks++;
        if (last_out !== 16'h0010) begin errors++; $display("FAIL basic_last_out: %h expected 0010", last_out); end
        checks++;
        if (pc !== 4'd2 || busy !== 1'b0) begin errors++; $display("FAIL basic_pc: pc=%0d busy=%b expected 2 and 0", pc, busy); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs_q.size()) begin errors++; $display("FAIL basic_sb: no load seen, expected cpu_in %h", e); end
            else begin
                if (obs_q[obs_rd] !== e) begin errors++; $display("FAIL basic_sb: cpu_in %h expected %h", obs_q[obs_rd], e); end
                obs_rd++;
            end
        end
    endtask

    task automatic test_timeout();
        int n; logic [15:0] e;
        write_word(4'd0, 16'hD011);
        cpu_stuck = 1'b1;
        exp_q.push_back(16'hD011);
        pulse_start(5'd1);
        n = 0;
        while (!cpu_s && n < 10) begin @(negedge clk); n++; end
        checks++;
        if (!cpu_s) begin errors++; $display("FAIL timeout_start: cpu_s=%b expected 1", cpu_s); end
        n = 0;
        while (!error && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (n != TIMEOUT + 1) begin errors++; $display("FAIL timeout_cycles: error after %0d cycles expected %0d", n, TIMEOUT + 1); end
        checks++;
        if (error !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || pc !== 4'd0) begin
            errors++; $display("FAIL timeout_state: error=%b busy=%b done=%b pc=%0d expected 1 0 0 0", error, busy, done, pc);
        end
        checks++;
        if (cpu_in !== 16'hD011) begin errors++; $display("FAIL timeout_cpu_in: %h expected d011", cpu_in); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs_q.size()) begin errors++; $display("FAIL timeout_sb: no load seen, expected cpu_in %h", e); end
            else begin
                if (obs_q[obs_rd] !== e) begin errors++; $display("FAIL timeout_sb: cpu_in %h expected %h", obs_q[obs_rd], e); end
                obs_rd++;
            end
        end
        cpu_stuck = 1'b0;
    endtask

    task automatic test_count_zero();
        int l0, s0;
        l0 = load_cnt; s0 = s_cnt;
        pulse_start(5'd0);
        checks++;
        if (done !== 1'b1 || error !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL zero_done: done=%b error=%b busy=%b expected 1 0 0", done, error, busy);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (load_cnt != l0 || s_cnt != s0) begin
            errors++; $display("FAIL zero_pulses: loads=%0d s=%0d expected 0 and 0", load_cnt - l0, s_cnt - s0);
        end
    endtask

    task automatic test_write_with_start();
        int cyc; bit ok; logic [15:0] e;
        prog_we = 1'b1; prog_addr = 4'd0; prog_data = 16'hD00A;
        start = 1'b1; count = 5'd1;
        exp_q.push_back(16'hD00A);
        @(negedge clk);
        prog_we = 1'b0; start = 1'b0;
        wait_done(100, cyc, ok);
        checks++;
        if (!ok || cyc != 6) begin errors++; $display("FAIL same_cycle_done: done=%b after %0d cycles expected 1 after 6", done, cyc); end
        checks++;
        if (last_out !== 16'h000A) begin errors++; $display("FAIL same_cycle_last_out: %h expected 000a", last_out); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs_q.size()) begin errors++; $display("FAIL same_cycle_sb: no load seen, expected cpu_in %h", e); end
            else begin
                if (obs_q[obs_rd] !== e) begin errors++; $display("FAIL same_cycle_sb: cpu_in %h expected %h", obs_q[obs_rd], e); end
                obs_rd++;
            end
        end
    endtask

    task automatic test_reset_midrun();
        int k; int n; int cyc; bit ok; logic [15:0] e;
        write_word(4'd0, 16'hD007);
        write_word(4'd1, 16'hD102);
        write_word(4'd2, 16'hA148);
        cpu_delay = 3;
        exp_q.push_back(16'hD007); exp_q.push_back(16'hD102); exp_q.push_back(16'hA148);
        pulse_start(5'd3);
        k = 0; n = 0;
        while (k < 2 && n < 100) begin
            if (cpu_s) k++;
            if (k < 2) begin @(negedge clk); n++; end
        end
        repeat (2) @(negedge clk);
        checks++;
        if (pc !== 4'd1 || busy !== 1'b1 || cpu_w !== 1'b0 || last_out !== 16'h0007) begin
            errors++; $display("FAIL midrun_wait_high: pc=%0d busy=%b w=%b last_out=%h expected 1 1 0 0007", pc, busy, cpu_w, last_out);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, error, cpu_load, cpu_s} !== 5'b0 || cpu_in !== 16'h0 || pc !== 4'h0 || last_out !== 16'h0) begin
            errors++; $display("FAIL midrun_reset: flags=%b cpu_in=%h pc=%h last_out=%h expected all 0",
                               {busy, done, error, cpu_load, cpu_s}, cpu_in, pc, last_out);
        end
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs_q.size()) begin errors++; $display("FAIL midrun_sb: no load seen, expected cpu_in %h", e); end
            else begin
                if (obs_q[obs_rd] !== e) begin errors++; $display("FAIL midrun_sb: cpu_in %h expected %h", obs_q[obs_rd], e); end
                obs_rd++;
            end
        end
        exp_q.delete();
        checks++;
        if (obs_rd != obs_q.size()) begin errors++; $display("FAIL midrun_extra: %0d loads expected 2", obs_q.size() - obs_rd + 2); end
        obs_rd = obs_q.size();
        repeat (6) @(negedge clk);
        cpu_delay = 0;
        exp_q.push_back(16'hD007); exp_q.push_back(16'hD102); exp_q.push_back(16'hA148);
        pulse_start(5'd3);
        wait_done(200, cyc, ok);
        checks++;
        if (!ok || cyc != 16 || last_out !== 16'h0010) begin
            errors++; $display("FAIL rerun_done: done=%b cycles=%0d last_out=%h expected 1 16 0010", done, cyc, last_out);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs_q.size()) begin errors++; $display("FAIL rerun_sb: no load seen, expected cpu_in %h", e); end
            else begin
                if (obs_q[obs_rd] !== e) begin errors++; $display("FAIL rerun_sb: cpu_in %h expected %h", obs_q[obs_rd], e); end
                obs_rd++;
            end
        end
    endtask

    task automatic test_ignore_and_clamp();
        int cyc; int l0; logic [15:0] w; logic [15:0] e;
        for (int i = 0; i < 16; i++) begin
            w = 16'hD000 | 16'((i % 8) << 8) | 16'(i * 3);
            write_word(4'(i), w);
            exp_q.push_back(w);
        end
        l0 = load_cnt;
        pulse_start(5'd20);
        cyc = 1;
        while (!done && !error && cyc < 400) begin
            if (cyc == 12) begin
                start = 1'b1; count = 5'd2;
                prog_we = 1'b1; prog_addr = 4'd5; prog_data = 16'hFFFF;
            end
            @(negedge clk);
            cyc++;
            start = 1'b0; prog_we = 1'b0;
        end
        checks++;
        if (!done || cyc != 81) begin errors++; $display("FAIL clamp_done: done=%b after %0d cycles expected 1 after 81", done, cyc); end
        checks++;
        if (load_cnt - l0 != 16) begin errors++; $display("FAIL clamp_loads: %0d expected 16", load_cnt - l0); end
        checks++;
        if (pc !== 4'd15 || last_out !== 16'h002D) begin
            errors++; $display("FAIL clamp_final: pc=%0d last_out=%h expected 15 002d", pc, last_out);
        end
        checks++;
        if (cpu_in !== 16'hD72D) begin errors++; $display("FAIL clamp_cpu_in: %h expected d72d", cpu_in); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs_q.size()) begin errors++; $display("FAIL clamp_sb: no load seen, expected cpu_in %h", e); end
            else begin
                if (obs_q[obs_rd] !== e) begin errors++; $display("FAIL clamp_sb: cpu_in %h expected %h", obs_q[obs_rd], e); end
                obs_rd++;
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic_run();
        test_timeout();
        test_count_zero();
        test_write_with_start();
        test_reset_midrun();
        test_ignore_and_clamp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
